counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Command-driven controller for the 8-bit counter datapath. Accepts start/stop/resume/clear/configure commands over a valid/ready port and owns the counter state: terminal value, direction, and continuous vs one-shot mode. Advances the count on qualified `tick` cycles and reports wrap events and completion to surrounding logic. Sits between the system command bus and anything consuming the count value or terminal-count pulse.

## Interface
- `WIDTH`, 8: counter width in bits.
- `TERM_RESET`, 255: terminal value loaded at reset.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  count enable; the count advances only on cycles with `tick`=1 in RUN.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid` && `cmd_ready`.
- `cmd_op`  in  3  opcode: 0 NOP, 1 START, 2 START_ONESHOT, 3 STOP, 4 RESUME, 5 CLEAR, 6 SET_TERM, 7 SET_DIR.
- `cmd_data`  in  WIDTH  operand: terminal value for SET_TERM; bit0 = direction for SET_DIR (0 up, 1 down).
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  one-cycle terminal-count pulse, registered.
- `done`  out  1  high while in DONE.
- `busy`  out  1  high while in RUN or PAUSE.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - `count`=0, term=`TERM_RESET`, dir=up, state=IDLE.
  - `tc`=0, `done`=0, `busy`=0.
  - `cmd_ready`=1.
- States:
  - IDLE: cleared, not counting.
  - RUN: counting.
  - PAUSE: frozen; count held.
  - DONE: one-shot finished; count held.
- `cmd_ready` is combinational: low only when state=RUN and `cmd_op` is SET_TERM or SET_DIR. High in every other case.
- Accepted commands:
  - START / START_ONESHOT, any state: load `count` with 0 (up) or term (down), latch the mode, go to RUN.
  - STOP: RUN→PAUSE. Ignored in other states.
  - RESUME: PAUSE→RUN. Ignored in other states.
  - CLEAR, any state: `count`=0, go to IDLE. Term and dir are kept.
  - SET_TERM: term=`cmd_data`. If `count` > new term, `count` is clamped to the new term. State is unchanged.
  - SET_DIR: dir=`cmd_data[0]`. State is unchanged.
  - NOP: no effect.
- Counting in RUN with `tick`=1 and no command accepted that cycle:
  - Up: if `count`==term, wrap to 0 and raise `tc`; otherwise `count`+1.
  - Down: if `count`==0, wrap to term and raise `tc`; otherwise `count`−1.
  - One-shot mode: at the terminal condition, do not wrap. Hold `count` at term (up) or 0 (down), raise `tc`, go to DONE.
- A command accepted in the same cycle as `tick` takes precedence; that tick is dropped.
- Term=0: every tick is terminal. `count` stays 0 and `tc` pulses on every tick.
- Arithmetic is modulo 2^WIDTH. The term compare prevents any overflow or underflow wrap outside 0..term.

## Timing
- All outputs except `cmd_ready` are registered.
- Latency:
  - A command accepted at edge N is visible in `count`/`busy`/`done` after edge N.
  - A tick sampled at edge N updates `count` after edge N.
- `tc` is high for exactly the one cycle following the terminal edge, coincident with the wrapped or held `count`.
- Back-to-back terminal ticks give back-to-back `tc` pulses. There is no minimum spacing.
- Reset asserted mid-RUN forces the reset values immediately, asynchronously. The first command is accepted on the first edge after deassertion.

## Structure
- Shared package `counter_ctrl_pkg`:
  - opcode enum (3-bit);
  - state enum (IDLE/RUN/PAUSE/DONE);
  - DIR_UP/DIR_DOWN constants.
- Sub-module `counter_core`: synchronous loadable up/down counter.
  - Inputs: enable, load, load value, dir, term.
  - Outputs: count, terminal-hit flag (combinational).
- `counter_ctrl` holds the FSM, the config registers, the command decode, and the `tc`/`done` registers.

## Test plan
- Continuous up: reset, START, term=255, `tick` held high 256 cycles → `count` 0..255, wraps to 0, single `tc` pulse, `busy`=1 throughout.
- One-shot down: SET_DIR 1, SET_TERM 5, START_ONESHOT, tick every cycle → `count` 5,4,3,2,1,0, holds 0; `tc` 1 cycle; `done`=1; `busy`=0.
- Pause and config lockout:
  - RUN at `count`=10, STOP → `count` holds 10 with ticks present.
  - SET_TERM presented in RUN → `cmd_ready`=0; accepted in PAUSE with data 7 → `count` clamps to 7.
  - RESUME → continues 7→0 with `tc`.
- Collision: STOP presented with `tick`=1 at `count`=3 → `count` stays 3, state PAUSE.
- Term=0 edge: SET_TERM 0, START, 4 ticks → `count`=0 throughout, 4 `tc` pulses.
- Async reset mid-run: assert `rst` between edges at `count`=42 → `count`=0, `busy`=0, `tc`=0 immediately; START after release counts from 0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl_pkg
// Brief    : Shared opcode/state types and direction constants for the
//            counter controller.
// Revision : 1.0
// ============================================================================
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP           = 3'd0,
        OP_START         = 3'd1,
        OP_START_ONESHOT = 3'd2,
        OP_STOP          = 3'd3,
        OP_RESUME        = 3'd4,
        OP_CLEAR         = 3'd5,
        OP_SET_TERM      = 3'd6,
        OP_SET_DIR       = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
// Module   : counter_core
// Brief    : Loadable up/down counter bounded to 0..term, with a
//            combinational terminal-hit flag.
// Revision : 1.0
// ============================================================================
module counter_core
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             hit
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    assign count = r_count;
    assign hit   = (dir == c_DIR_DOWN) ? (r_count == '0) : (r_count == term);

    // Wrapping at the terminal point keeps the value inside 0..term.
    always_comb begin
        w_next = r_count;
        if (dir == c_DIR_DOWN)
            w_next = hit ? term : r_count - 1'b1;
        else
            w_next = hit ? '0 : r_count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (load)
            r_count <= load_val;
        else if (en)
            r_count <= w_next;
    end

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Brief    : Command-driven controller (FSM, config registers, tc/done)
//            around an 8-bit up/down counter.
// Revision : 1.0
// ============================================================================
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TERM_RESET = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    opcode_e          w_op;
    logic [WIDTH-1:0] r_term;
    logic             r_dir;
    logic             r_oneshot;
    logic             r_tc;
    logic             r_done;
    logic             r_busy;
    logic             w_accept;
    logic             w_tick_run;
    logic             w_hit;
    logic             w_en;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_count;

    assign w_op       = opcode_e'(cmd_op);
    assign cmd_ready  = !((r_state == ST_RUN) &&
                          ((w_op == OP_SET_TERM) || (w_op == OP_SET_DIR)));
    assign w_accept   = cmd_valid && cmd_ready;
    // Any accepted command, even a no-op, consumes the cycle's tick.
    assign w_tick_run = !w_accept && (r_state == ST_RUN) && tick;
    assign w_en       = w_tick_run && !(r_oneshot && w_hit);

    assign count = w_count;
    assign tc    = r_tc;
    assign done  = r_done;
    assign busy  = r_busy;

    always_comb begin
        w_load      = 1'b0;
        w_load_val  = '0;
        w_state_nxt = r_state;
        if (w_accept) begin
            case (w_op)
                OP_START, OP_START_ONESHOT: begin
                    w_load      = 1'b1;
                    w_load_val  = (r_dir == c_DIR_DOWN) ? r_term : '0;
                    w_state_nxt = ST_RUN;
                end
                OP_STOP:   if (r_state == ST_RUN)   w_state_nxt = ST_PAUSE;
                OP_RESUME: if (r_state == ST_PAUSE) w_state_nxt = ST_RUN;
                OP_CLEAR: begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                OP_SET_TERM: begin
                    w_load     = (w_count > cmd_data);
                    w_load_val = cmd_data;
                end
                default: ;
            endcase
        end else if (w_tick_run && r_oneshot && w_hit) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_term    <= WIDTH'(TERM_RESET);
            r_dir     <= c_DIR_UP;
            r_oneshot <= 1'b0;
            r_tc      <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_tc    <= w_tick_run && w_hit;
            if (w_accept) begin
                case (w_op)
                    OP_START:         r_oneshot <= 1'b0;
                    OP_START_ONESHOT: r_oneshot <= 1'b1;
                    OP_SET_TERM:      r_term    <= cmd_data;
                    OP_SET_DIR:       r_dir     <= cmd_data[0];
                    default: ;
                endcase
            end
        end
    end

    counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (w_en),
        .load     (w_load),
        .load_val (w_load_val),
        .dir      (r_dir),
        .term     (r_term),
        .count    (w_count),
        .hit      (w_hit)
    );

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_ctrl
// Brief    : Directed and randomized bench for counter_ctrl against a
//            behavioural model of the command/count rules.
// Revision : 1.0
// ============================================================================
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [7:0] count;
    logic       tc;
    logic       done;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int tc_seen  = 0;

    // Behavioural model: st 0=idle 1=run 2=pause 3=done
    int m_cnt, m_term, m_dir, m_st, m_one, m_tc;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(8), .TERM_RESET(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (count),
        .tc        (tc),
        .done      (done),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_term = 255; m_dir = 0; m_st = 0; m_one = 0; m_tc = 0;
    endtask

    task automatic step(input logic t, input logic v, input int op, input int d);
        bit rdy;
        tick = t; cmd_valid = v; cmd_op = 3'(op); cmd_data = 8'(d);
        #1;
        rdy = !(m_st == 1 && (op == 6 || op == 7));
        chk("cmd_ready", int'(cmd_ready), int'(rdy));
        m_tc = 0;
        if (v && rdy) begin
            case (op)
                1, 2: begin m_cnt = m_dir ? m_term : 0; m_one = (op == 2); m_st = 1; end
                3: if (m_st == 1) m_st = 2;
                4: if (m_st == 2) m_st = 1;
                5: begin m_cnt = 0; m_st = 0; end
                6: begin m_term = d; if (m_cnt > m_term) m_cnt = m_term; end
                7: m_dir = d % 2;
                default: ;
            endcase
        end else if (m_st == 1 && t) begin
            if ((m_dir == 0 && m_cnt == m_term) || (m_dir == 1 && m_cnt == 0)) begin
                m_tc = 1;
                if (m_one) m_st = 3;
                else m_cnt = m_dir ? m_term : 0;
            end else begin
                m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("count", int'(count), m_cnt);
        chk("tc", int'(tc), m_tc);
        chk("done", int'(done), int'(m_st == 3));
        chk("busy", int'(busy), int'(m_st == 1 || m_st == 2));
        if (tc) tc_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        #9 rst = 1'b0;

        // Continuous up over the full range
        step(1'b0, 1'b1, 1, 0);
        tc_seen = 0;
        ticks(256);
        chk("up_wrap_count", int'(count), 0);
        chk("up_tc_pulses", tc_seen, 1);
        chk("up_busy", int'(busy), 1);

        // One-shot down from 5
        step(1'b0, 1'b1, 5, 0);
        step(1'b0, 1'b1, 7, 1);
        step(1'b0, 1'b1, 6, 5);
        step(1'b0, 1'b1, 2, 0);
        chk("os_load", int'(count), 5);
        tc_seen = 0;
        ticks(8);
        chk("os_count", int'(count), 0);
        chk("os_done", int'(done), 1);
        chk("os_busy", int'(busy), 0);
        chk("os_tc_pulses", tc_seen, 1);

        // Pause, config lockout in RUN, clamp in PAUSE, resume to wrap
        step(1'b0, 1'b1, 5, 0);
        step(1'b0, 1'b1, 7, 0);
        step(1'b0, 1'b1, 6, 255);
        step(1'b0, 1'b1, 1, 0);
        ticks(10);
        step(1'b0, 1'b1, 6, 7);
        chk("lock_ready", int'(cmd_ready), 0);
        chk("lock_count", int'(count), 10);
        step(1'b1, 1'b1, 3, 0);
        ticks(3);
        chk("pause_hold", int'(count), 10);
        step(1'b0, 1'b1, 6, 7);
        chk("clamp", int'(count), 7);
        step(1'b0, 1'b1, 4, 0);
        tc_seen = 0;
        ticks(1);
        chk("resume_wrap", int'(count), 0);
        chk("resume_tc", tc_seen, 1);

        // Command and tick in the same cycle
        step(1'b0, 1'b1, 5, 0);
        step(1'b0, 1'b1, 1, 0);
        ticks(3);
        step(1'b1, 1'b1, 3, 0);
        ticks(1);
        chk("coll_count", int'(count), 3);
        chk("coll_busy", int'(busy), 1);

        // Term = 0: every tick terminal
        step(1'b0, 1'b1, 5, 0);
        step(1'b0, 1'b1, 6, 0);
        step(1'b0, 1'b1, 1, 0);
        tc_seen = 0;
        ticks(4);
        chk("t0_count", int'(count), 0);
        chk("t0_tc_pulses", tc_seen, 4);

        // Asynchronous reset between edges
        step(1'b0, 1'b1, 5, 0);
        step(1'b0, 1'b1, 6, 255);
        step(1'b0, 1'b1, 1, 0);
        ticks(42);
        chk("pre_rst_count", int'(count), 42);
        tick = 1'b0; cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_tc", int'(tc), 0);
        #3 rst = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 1, 0);
        ticks(1);
        chk("post_rst_count", int'(count), 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int op, d;
            op = int'($urandom_range(0, 7));
            d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), op, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
